// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, the address/data width and the default reset PC.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/stall event counters for the fetch sequencer.
// Ports: clk, rst (async high), fire/stall event strobes, fetch_count, stall_count.
module fetch_perf_counters
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            fire,
    input  logic            stall,
    output logic [XLEN-1:0] fetch_count,
    output logic [XLEN-1:0] stall_count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fire && (fetch_count != '1))
                fetch_count <= fetch_count + 1'b1;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one imem read at a time, holds the
// result for decode, handles branch redirects and a sticky fetch timeout.
// Ports: clk, rst (async high), enable, isBranch/jump_value (redirect),
//   imem_req/imem_addr/imem_ready/imem_data (memory), instruction/instr_pc/
//   instr_valid/instr_ready (decode handshake), pc, fetch_err.
// Build option FETCH_PERF_CNT_EN adds fetch_count and stall_count outputs.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            isBranch,
    input  logic [XLEN-1:0] jump_value,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_data,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] pc,
    output logic            fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] fetch_count,
    output logic [XLEN-1:0] stall_count
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [7:0]      wcnt, wcnt_nxt;
    logic            squash, squash_nxt;
    logic            err_nxt;
    logic            capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            wcnt        <= '0;
            squash      <= 1'b0;
            fetch_err   <= 1'b0;
            instruction <= '0;
            instr_pc    <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            wcnt      <= wcnt_nxt;
            squash    <= squash_nxt;
            fetch_err <= err_nxt;
            if (capture) begin
                instruction <= imem_data;
                instr_pc    <= pc;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        wcnt_nxt   = wcnt;
        squash_nxt = squash;
        err_nxt    = fetch_err;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A redirect in IDLE only moves pc; fetch starts next cycle.
                if (isBranch)
                    pc_nxt = jump_value;
                else if (enable)
                    state_nxt = ST_REQ;
            end
            ST_REQ: begin
                wcnt_nxt   = '0;
                squash_nxt = 1'b0;
                state_nxt  = ST_WAIT;
                if (isBranch) begin
                    pc_nxt     = jump_value;
                    squash_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                wcnt_nxt = wcnt + 8'd1;
                if (imem_ready) begin
                    if (squash || isBranch) begin
                        // Stale data: drop it and refetch from the new pc.
                        state_nxt  = ST_REQ;
                        squash_nxt = 1'b0;
                        if (isBranch)
                            pc_nxt = jump_value;
                    end else begin
                        capture   = 1'b1;
                        pc_nxt    = pc + 32'd1;
                        state_nxt = ST_HOLD;
                    end
                end else begin
                    if (isBranch) begin
                        pc_nxt     = jump_value;
                        squash_nxt = 1'b1;
                    end
                    // Timeout wins even over a pending squash.
                    if (wcnt == WAIT_LAST) begin
                        state_nxt = ST_ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (isBranch) begin
                    pc_nxt    = jump_value;
                    state_nxt = ST_REQ;
                end else if (instr_ready) begin
                    state_nxt = enable ? ST_REQ : ST_IDLE;
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = imem_req ? pc : '0;
    assign instr_valid = (state == ST_HOLD);

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .fire        (instr_valid & instr_ready),
        .stall       (state == ST_WAIT),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer.
// Memory responses are driven inline; a negedge monitor checks accepted instructions.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        isBranch = 1'b0;
    logic [31:0] jump_value = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = '0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc;
    logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .isBranch    (isBranch),
        .jump_value  (jump_value),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .fetch_err   (fetch_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underrun", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", instruction, e.ins);
                chk("sb_pc", instr_pc, e.pc);
            end
        end
    end

    task automatic wait_req(input logic [31:0] addr);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
        chk("imem_addr", imem_addr, addr);
    endtask

    // Return data during the given WAIT cycle; optionally expect it presented.
    task automatic respond(input int waits, input logic [31:0] data,
                           input logic [31:0] addr, input bit present);
        tick();
        chk("req_one_cycle", 32'(imem_req), 32'd0);
        repeat (waits - 1) tick();
        imem_ready = 1'b1;
        imem_data  = data;
        if (present)
            sb.push_back({addr, data});
        tick();
        imem_ready = 1'b0;
        if (present) begin
            chk("valid", 32'(instr_valid), 32'd1);
            chk("pc_inc", pc, addr + 32'd1);
        end
    endtask

    task automatic serve(input logic [31:0] addr, input int waits,
                         input logic [31:0] data);
        wait_req(addr);
        respond(waits, data, addr, 1'b1);
    endtask

    initial begin
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_instr", instruction, 32'h0);
        tick();
        rst = 1'b0;
        enable = 1'b1;
        instr_ready = 1'b1;

        // Basic fetches; the second request follows at addr 1.
        serve(32'h0, 1, 32'hA0);
        serve(32'h1, 2, 32'hA1);

        // Redirect coincident with returning data in WAIT.
        wait_req(32'h2);
        tick();
        isBranch   = 1'b1;
        jump_value = 32'h40;
        imem_ready = 1'b1;
        imem_data  = 32'hBAD;
        tick();
        isBranch   = 1'b0;
        imem_ready = 1'b0;
        chk("br_wait_pc", pc, 32'h40);
        serve(32'h40, 1, 32'hC0);

        // Redirect during REQ squashes that access.
        wait_req(32'h41);
        isBranch   = 1'b1;
        jump_value = 32'h80;
        tick();
        isBranch = 1'b0;
        chk("br_req_pc", pc, 32'h80);
        imem_ready = 1'b1;
        imem_data  = 32'hBAD;
        tick();
        imem_ready = 1'b0;
        chk("br_req_novalid", 32'(instr_valid), 32'd0);
        serve(32'h80, 1, 32'hD0);

        // Decode stalls in HOLD, then a redirect flushes the held word.
        wait_req(32'h81);
        instr_ready = 1'b0;
        respond(1, 32'hE0, 32'h81, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instruction, 32'hE0);
            chk("hold_ipc", instr_pc, 32'h81);
            chk("hold_noreq", 32'(imem_req), 32'd0);
            tick();
        end
        isBranch   = 1'b1;
        jump_value = 32'h100;
        tick();
        isBranch = 1'b0;
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("flush_pc", pc, 32'h100);
        instr_ready = 1'b1;
        serve(32'h100, 1, 32'hF0);

        // Enable drops mid-access: finish, hand off, then idle.
        wait_req(32'h101);
        enable = 1'b0;
        respond(2, 32'h11, 32'h101, 1'b1);
        repeat (4) begin
            tick();
            chk("idle_noreq", 32'(imem_req), 32'd0);
        end
        chk("idle_pc", pc, 32'h102);

        // Redirect in IDLE, then the pc wraps past all-ones.
        isBranch   = 1'b1;
        jump_value = 32'hFFFF_FFFF;
        tick();
        isBranch = 1'b0;
        chk("br_idle_pc", pc, 32'hFFFF_FFFF);
        enable = 1'b1;
        serve(32'hFFFF_FFFF, 1, 32'h22);
        chk("wrap_pc", pc, 32'h0);

        // Reset mid-WAIT clears outputs without a clock edge.
        wait_req(32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_req", 32'(imem_req), 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_instr", instruction, 32'h0);
        chk("mrst_ipc", instr_pc, 32'h0);
        chk("mrst_pc", pc, 32'h0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        imem_ready = 1'b1;
        imem_data  = 32'hBAD;
        tick();
        imem_ready = 1'b0;
        tick();
        chk("late_ready_valid", 32'(instr_valid), 32'd0);
        chk("late_ready_pc", pc, 32'h0);

        // Timeout after four WAIT cycles; ERR ignores redirects.
        enable = 1'b1;
        wait_req(32'h0);
        repeat (4) tick();
        chk("to_early", 32'(fetch_err), 32'd0);
        tick();
        chk("to_err", 32'(fetch_err), 32'd1);
        isBranch   = 1'b1;
        jump_value = 32'h55;
        tick();
        isBranch = 1'b0;
        repeat (3) begin
            tick();
            chk("err_noreq", 32'(imem_req), 32'd0);
        end
        chk("err_pc", pc, 32'h0);
        chk("err_sticky", 32'(fetch_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("err_clr", 32'(fetch_err), 32'd0);
        tick();
        rst = 1'b0;

        // Three fetches with two wait cycles each.
        serve(32'h0, 2, 32'h30);
        serve(32'h1, 2, 32'h31);
        wait_req(32'h2);
        enable = 1'b0;
        respond(2, 32'h32, 32'h2, 1'b1);
        repeat (3) tick();
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'd3);
        chk("stall_count", stall_count, 32'd6);
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the word address loaded into pc on reset.
REQ-002 Parameter MAX_WAIT, default 15, SHALL be the maximum WAIT cycles allowed before a fetch timeout (range 1..255).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 enable  in  1  SHALL permit new fetch requests when high.
REQ-006 isBranch  in  1  SHALL be a one-cycle redirect strobe.
REQ-007 jump_value  in  32  SHALL be the redirect target word address, sampled when isBranch=1.
REQ-008 imem_req  out  1  SHALL be the one-cycle instruction-memory read strobe.
REQ-009 imem_addr  out  32  SHALL be the read word address, valid while imem_req=1.
REQ-010 imem_ready  in  1  SHALL be the one-cycle pulse marking imem_data valid.
REQ-011 imem_data  in  32  SHALL be the read data from instruction memory.
REQ-012 instruction  out  32  SHALL be the fetched instruction, held while instr_valid=1.
REQ-013 instr_pc  out  32  SHALL be the address of the instruction on the instruction output.
REQ-014 instr_valid  out  1 / instr_ready  in  1  SHALL form the valid/ready handshake to decode.
REQ-015 pc  out  32  SHALL be the next address to be fetched.
REQ-016 fetch_err  out  1  SHALL be a sticky timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, HOLD and ERR.
REQ-018 IDLE: outputs inactive; enable=1 -> REQ next cycle.
REQ-019 REQ: imem_req=1 and imem_addr=pc for exactly one cycle; wait counter cleared; -> WAIT.
REQ-020 WAIT: wait counter +1 per cycle; on imem_ready, register imem_data into instruction, set instr_pc=pc, set pc=pc+1 (mod 2^32, 32'hFFFF_FFFF wraps to 0), -> HOLD.
REQ-021 WAIT: when the counter reaches MAX_WAIT without imem_ready -> ERR and set fetch_err=1.
REQ-022 HOLD: instr_valid=1 and instruction/instr_pc stable; on instr_ready, -> REQ if enable=1, else -> IDLE; instr_valid is low in the following cycle.
REQ-023 ERR: all strobes low; the FSM stays in ERR and isBranch is ignored until rst.
REQ-024 Latency: at least 3 cycles from entering REQ to instr_valid (REQ, WAIT ≥1 cycle, HOLD); back-to-back throughput is 1 instruction per 3 cycles with zero-wait memory.
REQ-025 isBranch in IDLE: pc=jump_value; state unchanged.
REQ-026 isBranch in REQ: pc=jump_value; -> WAIT with squash=1; the returning data SHALL be discarded, then -> REQ.
REQ-027 isBranch in WAIT, before or coincident with imem_ready: pc=jump_value; the returning data is discarded and never presented; -> REQ after imem_ready.
REQ-028 isBranch in HOLD without instr_ready: the held instruction is flushed; instr_valid is low next cycle; pc=jump_value; -> REQ.
REQ-029 isBranch in HOLD with instr_ready in the same cycle: the handshake completes (instruction consumed); pc=jump_value; -> REQ.
REQ-030 enable dropping in REQ or WAIT SHALL NOT abort the outstanding access; it is completed and held, then the FSM goes -> IDLE after consumption.
REQ-031 A timeout during a squashed access SHALL still enter ERR.

Reset
REQ-032 On rst=1: state=IDLE, pc=RESET_PC, instruction=0, instr_pc=0, instr_valid=0, imem_req=0, imem_addr=0, fetch_err=0, squash=0, wait counter=0; this takes effect immediately, including mid-access.
REQ-033 An imem_ready arriving after reset deassertion for a pre-reset request SHALL be ignored, because the FSM is in IDLE or REQ.

Configuration
REQ-034 With macro FETCH_PERF_CNT_EN defined, the module SHALL add ports fetch_count out 32 (increments on each instr_valid & instr_ready) and stall_count out 32 (increments on each WAIT cycle); both saturate at 32'hFFFF_FFFF and reset to 0.
REQ-035 With FETCH_PERF_CNT_EN undefined, those ports and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-036 Shared package fetch_pkg SHALL hold the FSM state encoding, the address/data width constant (32), and the default RESET_PC.
REQ-037 The counters in REQ-034 SHALL be a sub-module fetch_perf_counters, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-038 Reset, enable=1, memory returns 32'hA0 after 1 wait cycle, instr_ready=1 -> imem_addr=0, instruction=32'hA0, instr_pc=0, pc=1, then a new imem_req at addr 1.
REQ-039 isBranch with jump_value=32'h40 during WAIT, data 32'hBAD returned -> 32'hBAD never valid; the next imem_addr is 32'h40.
REQ-040 HOLD with instr_ready=0 for 5 cycles -> instruction/instr_pc stable and no imem_req; isBranch=1 -> instr_valid low next cycle; next fetch at jump_value.
REQ-041 MAX_WAIT=4, memory never ready -> fetch_err=1 after 4 WAIT cycles; isBranch ignored; rst clears fetch_err and sets pc=RESET_PC.
REQ-042 pc=32'hFFFF_FFFF fetch completes -> pc=0; rst asserted mid-WAIT -> all outputs at reset values in the same cycle.
REQ-043 With FETCH_PERF_CNT_EN, 3 fetches each with 2 wait cycles -> fetch_count=3 and stall_count=6.
